ofm_relu_packer: RTL and testbench
==================================

Name: ofm_relu_packer

Overview:
- Output-side consumer of the convolution accelerator's two OFM result ports (ofm_port0/ofm_port1 with per-port valid).
- Applies ReLU, requantizes each 25-bit signed result to an unsigned byte, and packs bytes into 32-bit words.
- Buffers the words in a FIFO and streams them to the write-back/DMA path over a valid/ready interface with end-of-layer marking.
- The accelerator cannot be stalled, so this block absorbs bursts and flags any loss.

Parameters:
IN_W, 25, width of signed OFM results
OUT_W, 8, quantized element width (unsigned)
PACK, 4, elements per output word (output word = OUT_W*PACK bits)
FIFO_DEPTH, 16, output word FIFO entries
FIFO_AW, 4, log2(FIFO_DEPTH)
CNT_W, 16, element counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a new layer, clears counters and sticky flags
shift_amt  in  5  requant right-shift, sampled on start
expected_cnt  in  CNT_W  elements in layer, sampled on start
ofm_port0  in  IN_W  signed result, lane A
ofm_port0_v  in  1  lane A valid
ofm_port1  in  IN_W  signed result, lane B
ofm_port1_v  in  1  lane B valid
m_data  out  OUT_W*PACK  packed word; element i in bits [8i+7:8i]
m_valid  out  1  word available
m_ready  in  1  downstream accept
m_last  out  1  final word of layer, qualified by m_valid
busy  out  1  high in RUN or FLUSH
done  out  1  high in DONE until next start
overflow  out  1  sticky; word dropped because FIFO was full
elem_cnt  out  CNT_W  elements accepted this layer

Behaviour:
- Reset value of every output is 0. State is IDLE. FIFO and packer are empty.
- States:
  - IDLE: on start, go to RUN.
  - RUN: when elem_cnt reaches expected_cnt, go to FLUSH.
  - FLUSH: when the FIFO is empty and the last word has been handshaken, go to DONE.
  - DONE: on start, go to RUN.
- start is ignored in RUN and FLUSH.
- Accepting start: latches shift_amt and expected_cnt; clears elem_cnt, overflow and packer lanes. The FIFO is already empty at that point.
- expected_cnt=0: RUN goes to FLUSH on the next cycle. No word is pushed, m_last is never asserted, then DONE.
- Valids are ignored outside RUN. Elements beyond expected_cnt are ignored. When both ports are valid and only one element remains, port0 is taken.
- Per-element arithmetic (stage 1, registered):
  - Negative values become 0.
  - Then logical right shift by shift_amt (truncate).
  - Then saturate to 255.
- Order: when both ports are valid, port0 precedes port1. elem_cnt increments by 0, 1 or 2 per cycle.
- Packer (stage 2):
  - Lane pointer runs 0..PACK-1.
  - A word completes when lane PACK-1 is filled. It is written to the FIFO on the same edge the stage-2 update occurs.
  - With lane=3 and two elements arriving: the first completes the word, the second goes to lane 0 of the next word.
  - Final element of the layer: the partial word is zero-padded in the upper lanes, pushed with last=1, and the lane pointer resets.
- Latency: element sampled at edge k is registered at edge k. It is pushed at edge k+1 if it completes a word. m_valid is high after edge k+1 (2 cycles).
- FIFO:
  - First-word-fall-through; stores {last, data}.
  - Pop on m_valid&&m_ready.
  - Push and pop in the same cycle are allowed when full.
  - A push when full and not popping drops the word and sets overflow (sticky until start). A dropped word carrying last still advances the state machine to FLUSH.
- m_data and m_last are held stable while m_valid&&!m_ready.
- Asynchronous reset mid-layer: immediate return to reset values; FIFO contents are discarded.

Test Plan:
- shift=0, expected=4, port0 only: 5, -3, 300, 255 on consecutive cycles -> single word 0xFFFF0005, m_last=1, m_valid 2 cycles after the 4th element, then done=1, elem_cnt=4.
- expected=4, both ports valid for 2 cycles: (1,2) then (3,4) -> 0x04030201, m_last=1.
- expected=7: port0 only 1,2,3, then dual (4,5), then dual (6,7) -> words 0x04030201 then 0x00070605 with last. Checks the lane-3 spill.
- shift=4, expected=4: inputs 4096, 40, 15, -1 -> 0x0000_02FF (bytes 255, 2, 0, 0).
- m_ready=0, expected=68, single port at full rate -> 17 words generated, overflow=1 on the 17th. With m_ready=1, 16 words are then delivered in order. FLUSH still reaches DONE.
- rst_n low after 2 elements of expected=4 -> all outputs 0 immediately. Valids in IDLE afterwards do not change elem_cnt and produce no m_valid.

Source files
------------

// File: rtl/ofm_relu_packer.sv
// Output-side ReLU/requantize/pack stage for the conv accelerator's two OFM ports.
// Packs unsigned bytes into words, buffers them in a FWFT FIFO and streams them out.
module ofm_relu_packer #(
  parameter int IN_W       = 25,
  parameter int OUT_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            shift_amt,
  input  logic [CNT_W-1:0]      expected_cnt,
  input  logic [IN_W-1:0]       ofm_port0,
  input  logic                  ofm_port0_v,
  input  logic [IN_W-1:0]       ofm_port1,
  input  logic                  ofm_port1_v,
  output logic [OUT_W*PACK-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      elem_cnt
);

  localparam int W_W    = OUT_W * PACK;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW     = FIFO_AW + 1;
  localparam int SP_W   = FIFO_AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [4:0]         r_shift;
  logic [CNT_W-1:0]   r_expected, r_elem_cnt;
  logic               r_overflow, r_last_seen;

  logic [1:0]         r_s1_n;
  logic [OUT_W-1:0]   r_s1_d0, r_s1_d1;
  logic               r_s1_last;

  logic [W_W-1:0]     r_pack;
  logic [LANE_W-1:0]  r_lane;

  logic [W_W:0]       r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0]      r_count;

  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] v,
                                               input logic [4:0]      sh);
    logic [IN_W-1:0] s;
    requant = '0;
    if (!v[IN_W-1]) begin
      s = v >> sh;
      if (|s[IN_W-1:OUT_W]) requant = '1;
      else                  requant = s[OUT_W-1:0];
    end
  endfunction

  // ---------------- element acceptance ----------------
  logic [CNT_W-1:0] w_rem;
  logic             w_take0, w_take1, w_last_in, w_start_ok;
  logic [1:0]       w_n;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_rem      = r_expected - r_elem_cnt;
  // Port0 wins the last slot when both lanes are valid.
  assign w_take0    = (r_state == S_RUN) && ofm_port0_v && (w_rem != '0);
  assign w_take1    = (r_state == S_RUN) && ofm_port1_v && (w_rem > CNT_W'(w_take0));
  assign w_n        = {1'b0, w_take0} + {1'b0, w_take1};
  assign w_last_in  = (w_n != 2'd0) && (w_rem == CNT_W'(w_n));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking is reserved for always_comb temporaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_expected <= '0;
      r_elem_cnt <= '0;
      r_s1_n     <= '0;
      r_s1_d0    <= '0;
      r_s1_d1    <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_start_ok) begin
      r_shift    <= shift_amt;
      r_expected <= expected_cnt;
      r_elem_cnt <= '0;
      r_s1_n     <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_elem_cnt <= r_elem_cnt + CNT_W'(w_n);
      r_s1_n     <= w_n;
      r_s1_d0    <= w_take0 ? requant(ofm_port0, r_shift) : requant(ofm_port1, r_shift);
      r_s1_d1    <= requant(ofm_port1, r_shift);
      r_s1_last  <= w_last_in;
    end
  end

  // ---------------- packer ----------------
  logic [W_W-1:0]    w_word;
  logic [LANE_W-1:0] w_lane;
  logic [1:0]        w_push_n;
  logic [W_W:0]      w_push0, w_push1;
  logic              w_is_last;

  // NOTE: every always_comb output gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_word    = r_pack;
    w_lane    = r_lane;
    w_push_n  = 2'd0;
    w_push0   = '0;
    w_push1   = '0;
    w_is_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (2'(i) < r_s1_n) begin
        w_word[w_lane*OUT_W +: OUT_W] = (i == 0) ? r_s1_d0 : r_s1_d1;
        w_is_last = r_s1_last && (2'(i + 1) == r_s1_n);
        if (w_lane == LANE_W'(PACK - 1) || w_is_last) begin
          if (w_push_n == 2'd0) w_push0 = {w_is_last, w_word};
          else                  w_push1 = {w_is_last, w_word};
          w_push_n = w_push_n + 2'd1;
          w_word   = '0;
          w_lane   = '0;
        end else begin
          w_lane = w_lane + LANE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack <= '0;
      r_lane <= '0;
    end else if (w_start_ok) begin
      r_pack <= '0;
      r_lane <= '0;
    end else begin
      r_pack <= w_word;
      r_lane <= w_lane;
    end
  end

  // ---------------- FIFO (first-word-fall-through) ----------------
  logic            w_pop, w_acc0, w_acc1, w_drop, w_drop_last;
  logic [SP_W-1:0] w_space;
  logic [1:0]      w_n_acc;

  assign w_pop   = m_valid && m_ready;
  // A same-cycle pop frees a slot, so a full FIFO can still take a push.
  assign w_space = SP_W'(FIFO_DEPTH) - SP_W'(r_count) + SP_W'(w_pop);
  assign w_acc0  = (w_push_n != 2'd0) && (w_space >= SP_W'(1));
  assign w_acc1  = (w_push_n == 2'd2) && (w_space >= SP_W'(2));
  assign w_n_acc = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_drop  = ((w_push_n != 2'd0) && !w_acc0) || ((w_push_n == 2'd2) && !w_acc1);
  assign w_drop_last = ((w_push_n != 2'd0) && !w_acc0 && w_push0[W_W]) ||
                       ((w_push_n == 2'd2) && !w_acc1 && w_push1[W_W]);

  // NOTE: storage has no reset; the pointers/count define validity and the
  // outputs are gated by m_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[r_wptr] <= w_push0;
    if (w_acc1) r_mem[r_wptr + FIFO_AW'(1)] <= w_push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + FIFO_AW'(w_n_acc);
      r_rptr  <= r_rptr + FIFO_AW'(w_pop);
      r_count <= r_count + CW'(w_n_acc) - CW'(w_pop);
    end
  end

  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? r_mem[r_rptr][W_W-1:0] : '0;
  assign m_last  = m_valid && r_mem[r_rptr][W_W];

  // ---------------- flags and control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (w_start_ok) begin
      r_overflow  <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if ((w_pop && m_last) || w_drop_last) r_last_seen <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_RUN;
      S_RUN:   if (r_elem_cnt == r_expected) w_state_nx = S_FLUSH;
      // An empty layer has no last word to wait for.
      S_FLUSH: if (r_count == '0 && (r_last_seen || r_expected == '0)) w_state_nx = S_DONE;
      S_DONE:  if (start) w_state_nx = S_RUN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  assign busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done     = (r_state == S_DONE);
  assign overflow = r_overflow;
  assign elem_cnt = r_elem_cnt;

endmodule

// File: tb/tb_ofm_relu_packer.sv
// Directed testbench for ofm_relu_packer: hand-computed packed words, flags and
// counters across single/dual port, spill, shift, overflow and reset scenarios.
module tb_ofm_relu_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  shift_amt;
  logic [15:0] expected_cnt;
  logic [24:0] ofm_port0, ofm_port1;
  logic        ofm_port0_v, ofm_port1_v;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic        busy, done, overflow;
  logic [15:0] elem_cnt;

  int checks = 0;
  int errors = 0;

  ofm_relu_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_amt(shift_amt),
    .expected_cnt(expected_cnt),
    .ofm_port0(ofm_port0), .ofm_port0_v(ofm_port0_v),
    .ofm_port1(ofm_port1), .ofm_port1_v(ofm_port1_v),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .overflow(overflow), .elem_cnt(elem_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int v0, input logic e0, input int v1, input logic e1);
    @(negedge clk);
    ofm_port0   = 25'(v0);
    ofm_port0_v = e0;
    ofm_port1   = 25'(v1);
    ofm_port1_v = e1;
  endtask

  task automatic idle();
    drive(0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_start(input int sh, input int exp_cnt);
    @(negedge clk);
    start        = 1'b1;
    shift_amt    = 5'(sh);
    expected_cnt = 16'(exp_cnt);
    @(negedge clk);
    start        = 1'b0;
    shift_amt    = 5'd0;
    expected_cnt = 16'd0;
  endtask

  // Waits (bounded) for a word, captures it, then handshakes exactly once.
  task automatic get_word(output logic [31:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid) begin
        d  = m_data;
        l  = m_last;
        ok = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, m_last, busy, done, overflow, m_data, elem_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b o=%b data=%h cnt=%0d exp all 0",
               m_valid, m_last, busy, done, overflow, m_data, elem_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b m_valid=%b exp 000", busy, done, m_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic l; bit ok;
    do_start(0, 4);
    drive(5, 1, 0, 0);
    drive(-3, 1, 0, 0);
    drive(300, 1, 0, 0);
    drive(255, 1, 0, 0);
    idle();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early got m_valid=%b exp 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF0005 || m_last !== 1'b1) begin
      errors++;
      $display("FAIL basic_word got v=%b data=%h last=%b exp 1 ffff0005 1", m_valid, m_data, m_last);
    end
    get_word(d, l, ok);
    wait_done(ok);
    checks++;
    if (!ok || elem_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done_seen=%b cnt=%0d busy=%b exp 1 4 0", ok, elem_cnt, busy);
    end
  endtask

  task automatic test_dual();
    logic [31:0] d; logic l; bit ok;
    do_start(0, 4);
    drive(1, 1, 2, 1);
    drive(3, 1, 4, 1);
    idle();
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h04030201 || l !== 1'b1) begin
      errors++;
      $display("FAIL dual_word got ok=%b data=%h last=%b exp 04030201 1", ok, d, l);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dual_done got done never asserted exp done=1");
    end
  endtask

  task automatic test_spill();
    logic [31:0] d; logic l; bit ok;
    do_start(0, 7);
    drive(1, 1, 0, 0);
    drive(2, 1, 0, 0);
    drive(3, 1, 0, 0);
    drive(4, 1, 5, 1);
    drive(6, 1, 7, 1);
    idle();
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h04030201 || l !== 1'b0) begin
      errors++;
      $display("FAIL spill_word0 got ok=%b data=%h last=%b exp 04030201 0", ok, d, l);
    end
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h00070605 || l !== 1'b1) begin
      errors++;
      $display("FAIL spill_word1 got ok=%b data=%h last=%b exp 00070605 1", ok, d, l);
    end
    wait_done(ok);
    checks++;
    if (!ok || elem_cnt !== 16'd7) begin
      errors++;
      $display("FAIL spill_done got done_seen=%b cnt=%0d exp 1 7", ok, elem_cnt);
    end
  endtask

  // Lane-3 fill and final element in the same cycle: two pushes at once,
  // then extra valids beyond the layer must be ignored.
  task automatic test_double_push();
    logic [31:0] d; logic l; bit ok;
    do_start(0, 5);
    drive(1, 1, 0, 0);
    drive(2, 1, 0, 0);
    drive(3, 1, 0, 0);
    drive(4, 1, 5, 1);
    drive(77, 1, 88, 1);
    idle();
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h04030201 || l !== 1'b0) begin
      errors++;
      $display("FAIL dpush_word0 got ok=%b data=%h last=%b exp 04030201 0", ok, d, l);
    end
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h00000005 || l !== 1'b1) begin
      errors++;
      $display("FAIL dpush_word1 got ok=%b data=%h last=%b exp 00000005 1", ok, d, l);
    end
    wait_done(ok);
    checks++;
    if (!ok || elem_cnt !== 16'd5) begin
      errors++;
      $display("FAIL dpush_done got done_seen=%b cnt=%0d exp 1 5", ok, elem_cnt);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d; logic l; bit ok;
    do_start(0, 5);
    drive(1, 1, 0, 0);
    drive(2, 1, 0, 0);
    drive(3, 1, 0, 0);
    drive(4, 1, 0, 0);
    drive(5, 1, 99, 1);
    idle();
    get_word(d, l, ok);
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h00000005 || l !== 1'b1) begin
      errors++;
      $display("FAIL priority_word got ok=%b data=%h last=%b exp 00000005 1", ok, d, l);
    end
    wait_done(ok);
    checks++;
    if (!ok || elem_cnt !== 16'd5) begin
      errors++;
      $display("FAIL priority_cnt got done_seen=%b cnt=%0d exp 1 5", ok, elem_cnt);
    end
  endtask

  task automatic test_shift();
    logic [31:0] d; logic l; bit ok;
    do_start(4, 4);
    drive(0, 0, 4096, 1);
    drive(0, 0, 40, 1);
    drive(0, 0, 15, 1);
    drive(0, 0, -1, 1);
    idle();
    get_word(d, l, ok);
    checks++;
    if (!ok || d !== 32'h000002FF || l !== 1'b1) begin
      errors++;
      $display("FAIL shift_word got ok=%b data=%h last=%b exp 000002ff 1", ok, d, l);
    end
    wait_done(ok);
  endtask

  task automatic test_zero_len();
    bit seen_valid = 1'b0;
    bit ok = 1'b0;
    do_start(0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) seen_valid = 1'b1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || seen_valid || elem_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_len got done_seen=%b m_valid_seen=%b cnt=%0d exp 1 0 0", ok, seen_valid, elem_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e; logic l; bit ok;
    int bad = 0;
    do_start(0, 68);
    for (int i = 0; i < 68; i++) begin
      drive(i + 1, 1, 0, 0);
      if (i == 67) begin
        checks++;
        if (overflow !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h04030201) begin
          errors++;
          $display("FAIL ovf_before got ovf=%b v=%b data=%h exp 0 1 04030201", overflow, m_valid, m_data);
        end
      end
    end
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag got ovf=%b busy=%b done=%b exp 1 1 0", overflow, busy, done);
    end
    for (int j = 0; j < 16; j++) begin
      e = {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)};
      get_word(d, l, ok);
      checks++;
      if (!ok || d !== e || l !== 1'b0) begin
        errors++;
        bad++;
        $display("FAIL ovf_word%0d got ok=%b data=%h last=%b exp %h 0", j, ok, d, l, e);
      end
    end
    wait_done(ok);
    checks++;
    if (!ok || overflow !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_done got done_seen=%b ovf=%b v=%b exp 1 1 0", ok, overflow, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_start(0, 4);
    drive(9, 1, 0, 0);
    drive(10, 1, 0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (elem_cnt !== 16'd2) begin
      errors++;
      $display("FAIL mid_cnt got cnt=%0d exp 2", elem_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, busy, done, overflow, m_data, elem_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b busy=%b data=%h cnt=%0d exp all 0", m_valid, busy, m_data, elem_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 2, 1);
    drive(3, 1, 4, 1);
    drive(5, 1, 6, 1);
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (elem_cnt !== 16'd0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_valids got cnt=%0d v=%b busy=%b exp 0 0 0", elem_cnt, m_valid, busy);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    shift_amt    = '0;
    expected_cnt = '0;
    ofm_port0    = '0;
    ofm_port1    = '0;
    ofm_port0_v  = 1'b0;
    ofm_port1_v  = 1'b0;
    m_ready      = 1'b0;
    test_reset();
    test_basic();
    test_dual();
    test_spill();
    test_double_push();
    test_priority();
    test_shift();
    test_zero_len();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
